// File: rtl/job_scheduler.sv
// Job scheduler: queues descriptors in a FIFO and sequences them one at a time
// into the bitstream wrapper using a GO/DONE handshake, reporting each completion.
//
// state    | meaning
// S_IDLE   | waiting for a queued job, HOLD low and wrapper idle (DONE = 1)
// S_LAUNCH | GO asserted until the wrapper drops DONE
// S_RUN    | wrapper busy, waiting for DONE to return high
// S_CPL    | one-cycle completion pulse, then back to S_IDLE
module job_scheduler #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     JOB_VALID,
  output logic                     JOB_READY,
  input  logic [31:0]              JOB_SRC,
  input  logic [31:0]              JOB_DST,
  input  logic [31:0]              JOB_SIZE,
  input  logic [TAG_W-1:0]         JOB_TAG,
  input  logic                     HOLD,
  output logic                     GO,
  input  logic                     DONE,
  output logic [31:0]              SRC,
  output logic [31:0]              DST,
  output logic [31:0]              SIZE,
  output logic                     CPL_VALID,
  output logic [TAG_W-1:0]         CPL_TAG,
  output logic                     CPL_ERR,
  output logic [$clog2(DEPTH):0]   QCOUNT,
  output logic                     BUSY,
  output logic [15:0]              JOBS_DONE
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_CPL} state_t;

  state_t state, state_nxt;

  logic [31:0]      q_src  [DEPTH];
  logic [31:0]      q_dst  [DEPTH];
  logic [31:0]      q_size [DEPTH];
  logic [TAG_W-1:0] q_tag  [DEPTH];

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             push, pop, q_empty;
  logic             err_q;
  logic [TAG_W-1:0] tag_q;
  logic [15:0]      jobs_done_q;

  assign q_empty   = (count == '0);
  assign JOB_READY = (count != FULL_CNT);
  assign push      = JOB_VALID && JOB_READY;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    GO        = 1'b0;
    CPL_VALID = 1'b0;
    case (state)
      S_IDLE: begin
        if (!q_empty && !HOLD && DONE) begin
          pop = 1'b1;
          // zero-length jobs bypass the wrapper and complete with an error
          state_nxt = (q_size[rd_ptr] == 32'd0) ? S_CPL : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        GO = 1'b1;
        if (!DONE) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (DONE) state_nxt = S_CPL;
      end
      S_CPL: begin
        CPL_VALID = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      q_src[wr_ptr]  <= JOB_SRC;
      q_dst[wr_ptr]  <= JOB_DST;
      q_size[wr_ptr] <= JOB_SIZE;
      q_tag[wr_ptr]  <= JOB_TAG;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // current-job registers hold their value until the next pop
  always_ff @(posedge CLK) begin
    if (RST) begin
      SRC   <= '0;
      DST   <= '0;
      SIZE  <= '0;
      tag_q <= '0;
      err_q <= 1'b0;
    end else if (pop) begin
      SRC   <= q_src[rd_ptr];
      DST   <= q_dst[rd_ptr];
      SIZE  <= q_size[rd_ptr];
      tag_q <= q_tag[rd_ptr];
      err_q <= (q_size[rd_ptr] == 32'd0);
    end else if (state == S_CPL) begin
      err_q <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)                 jobs_done_q <= '0;
    else if (state == S_CPL) jobs_done_q <= jobs_done_q + 16'd1;
  end

  assign CPL_TAG   = tag_q;
  assign CPL_ERR   = (state == S_CPL) && err_q;
  assign QCOUNT    = count;
  assign BUSY      = (state != S_IDLE);
  assign JOBS_DONE = jobs_done_q;

endmodule

// File: tb/tb_job_scheduler.sv
// Bench for job_scheduler: directed scenarios plus randomized traffic, checked by a
// scoreboard of expected completions and a queue-occupancy model driven from events.
module tb_job_scheduler;
  localparam int DEPTH = 4;
  localparam int TAG_W = 8;
  localparam int QW    = $clog2(DEPTH) + 1;

  logic             CLK, RST, JOB_VALID, JOB_READY, HOLD, GO, DONE;
  logic [31:0]      JOB_SRC, JOB_DST, JOB_SIZE, SRC, DST, SIZE;
  logic [TAG_W-1:0] JOB_TAG, CPL_TAG;
  logic             CPL_VALID, CPL_ERR, BUSY;
  logic [QW-1:0]    QCOUNT;
  logic [15:0]      JOBS_DONE;

  logic wr_done  = 1'b1;
  logic ext_busy = 1'b0;
  assign DONE = wr_done && !ext_busy;

  job_scheduler #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .CLK(CLK), .RST(RST), .JOB_VALID(JOB_VALID), .JOB_READY(JOB_READY),
    .JOB_SRC(JOB_SRC), .JOB_DST(JOB_DST), .JOB_SIZE(JOB_SIZE), .JOB_TAG(JOB_TAG),
    .HOLD(HOLD), .GO(GO), .DONE(DONE), .SRC(SRC), .DST(DST), .SIZE(SIZE),
    .CPL_VALID(CPL_VALID), .CPL_TAG(CPL_TAG), .CPL_ERR(CPL_ERR),
    .QCOUNT(QCOUNT), .BUSY(BUSY), .JOBS_DONE(JOBS_DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [31:0]      size;
    logic [TAG_W-1:0] tag;
  } job_t;

  job_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired or unexpected event at %0t", name, $time);
  endtask

  // wrapper model: drops DONE some cycles after seeing GO, raises it after a busy period
  int wr_drop  = 0;
  int wr_busy  = 300;
  bit rand_wr  = 0;
  int cur_drop = 0;
  initial begin
    int d, b;
    forever begin
      @(negedge CLK);
      if (GO) begin
        d = rand_wr ? int'($urandom_range(0, 2)) : wr_drop;
        b = rand_wr ? int'($urandom_range(1, 8)) : wr_busy;
        cur_drop = d;
        if (d == 0) wr_done = 1'b0;
        else begin
          repeat (d) @(posedge CLK);
          #1 wr_done = 1'b0;
        end
        repeat (b) @(posedge CLK);
        #1 wr_done = 1'b1;
      end
    end
  end

  // monitor: occupancy model, scoreboard of completions, descriptor and GO checks
  int          cnt_m = 0;
  logic [15:0] jd_m = '0;
  int          go_len = 0;
  int          go_rises = 0;
  bit          push_prev = 0, busy_prev = 0, go_prev = 0, hold_prev = 0, done_prev = 0;
  always @(negedge CLK) begin
    if (RST) begin
      cnt_m = 0; jd_m = '0; push_prev = 0; busy_prev = 0; go_prev = 0; go_len = 0;
      hold_prev = HOLD; done_prev = DONE;
    end else begin
      if (push_prev) cnt_m++;
      if (BUSY && !busy_prev) begin
        cnt_m--;
        check("pop_hold_low", hold_prev, 0);
        check("pop_done_high", done_prev, 1);
      end
      check("qcount", QCOUNT, cnt_m);
      check("job_ready", JOB_READY, cnt_m != DEPTH);
      check("jobs_done", JOBS_DONE, jd_m);
      if (BUSY) begin
        if (exp_q.size() == 0) fail_now("busy_without_job");
        else begin
          check("src", SRC, exp_q[0].src);
          check("dst", DST, exp_q[0].dst);
          check("size", SIZE, exp_q[0].size);
        end
      end
      if (GO) begin
        go_len++;
        if (!go_prev) begin
          go_rises++;
          if (exp_q.size() == 0) fail_now("go_without_job");
          else check("go_size_nonzero", exp_q[0].size != 32'd0, 1);
        end
      end else if (go_prev) begin
        check("go_len", go_len, cur_drop + 1);
        go_len = 0;
      end
      if (CPL_VALID) begin
        if (exp_q.size() == 0) fail_now("cpl_without_job");
        else begin
          check("cpl_tag", CPL_TAG, exp_q[0].tag);
          check("cpl_err", CPL_ERR, exp_q[0].size == 32'd0);
          void'(exp_q.pop_front());
        end
        jd_m = jd_m + 16'd1;
      end
      push_prev = JOB_VALID && JOB_READY;
      busy_prev = BUSY;
      go_prev   = GO;
      hold_prev = HOLD;
      done_prev = DONE;
    end
  end

  task automatic sync();
    @(posedge CLK);
    #1;
  endtask

  // called just after a rising edge; returns just after the accepting edge
  task automatic push_job(input logic [31:0] s, input logic [31:0] d, input logic [31:0] z,
                          input logic [TAG_W-1:0] t);
    bit ok;
    job_t j;
    ok = 0;
    JOB_SRC = s; JOB_DST = d; JOB_SIZE = z; JOB_TAG = t; JOB_VALID = 1'b1;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(negedge CLK);
      if (JOB_READY) ok = 1;
      @(posedge CLK);
    end
    #1 JOB_VALID = 1'b0;
    if (ok) begin
      j.src = s; j.dst = d; j.size = z; j.tag = t;
      exp_q.push_back(j);
    end else fail_now("push_timeout");
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || BUSY || !wr_done) && n < 6000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 6000) fail_now("drain_timeout");
  endtask

  task automatic check_reset_vals();
    check("rst_go", GO, 0);
    check("rst_cpl_valid", CPL_VALID, 0);
    check("rst_cpl_err", CPL_ERR, 0);
    check("rst_cpl_tag", CPL_TAG, 0);
    check("rst_src", SRC, 0);
    check("rst_dst", DST, 0);
    check("rst_size", SIZE, 0);
    check("rst_jobs_done", JOBS_DONE, 0);
    check("rst_busy", BUSY, 0);
    check("rst_qcount", QCOUNT, 0);
    check("rst_job_ready", JOB_READY, 1);
  endtask

  task automatic reset_dut();
    @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    exp_q.delete();
    @(negedge CLK);
    check_reset_vals();
    @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  bit rand_on;
  int g0, n;

  initial begin
    RST = 1'b1; JOB_VALID = 1'b0; HOLD = 1'b0;
    JOB_SRC = '0; JOB_DST = '0; JOB_SIZE = '0; JOB_TAG = '0;
    reset_dut();

    // single job with a long wrapper run; GO two cycles after acceptance
    wr_drop = 0; wr_busy = 300; rand_wr = 0;
    g0 = go_rises;
    push_job(32'h1000, 32'h2000, 32'd256, 8'd5);
    @(negedge CLK); check("lat_go_t1", GO, 0);
    @(negedge CLK); check("lat_go_t2", GO, 1);
    wait_drain();
    check("single_jobs_done", JOBS_DONE, 1);
    check("single_go_count", go_rises - g0, 1);

    // fill the queue while held, fifth descriptor must wait for the first pop
    sync();
    wr_busy = 30;
    g0 = go_rises;
    HOLD = 1'b1;
    for (int i = 0; i < 4; i++) push_job(32'h100 * i, 32'h8000 + i, 32'd16 + i, TAG_W'(i));
    @(negedge CLK);
    check("full_qcount", QCOUNT, 4);
    check("full_ready", JOB_READY, 0);
    sync();
    fork
      push_job(32'h400, 32'h8004, 32'd20, 8'd4);
      begin
        repeat (5) @(posedge CLK);
        #1 check("fifth_held", exp_q.size(), 4);
        HOLD = 1'b0;
      end
    join
    wait_drain();
    check("five_go_count", go_rises - g0, 5);

    // zero-length job between two normal jobs
    sync();
    wr_busy = 4;
    g0 = go_rises;
    push_job(32'hA000, 32'hB000, 32'd10, 8'd1);
    push_job(32'hA100, 32'hB100, 32'd0,  8'd9);
    push_job(32'hA200, 32'hB200, 32'd5,  8'd2);
    wait_drain();
    check("zero_go_count", go_rises - g0, 2);

    // HOLD blocks launching; release gives GO two cycles later
    sync();
    wr_busy = 5;
    HOLD = 1'b1;
    push_job(32'h1, 32'h2, 32'd3, 8'd11);
    push_job(32'h4, 32'h5, 32'd6, 8'd12);
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    check("hold_qcount", QCOUNT, 2);
    check("hold_go", GO, 0);
    sync();
    HOLD = 1'b0;
    @(negedge CLK); check("hold_rel_go_t1", GO, 0);
    @(negedge CLK); check("hold_rel_go_t2", GO, 1);
    wait_drain();

    // wrapper still finishing: no pop until DONE rises
    sync();
    ext_busy = 1'b1;
    push_job(32'h77, 32'h88, 32'd9, 8'd13);
    repeat (8) @(posedge CLK);
    @(negedge CLK);
    check("done_low_go", GO, 0);
    check("done_low_qcount", QCOUNT, 1);
    check("done_low_busy", BUSY, 0);
    sync();
    ext_busy = 1'b0;
    @(negedge CLK); check("done_rise_go_t1", GO, 0);
    @(negedge CLK); check("done_rise_go_t2", GO, 1);
    wait_drain();

    // reset while the wrapper is running
    sync();
    wr_busy = 200;
    push_job(32'hDEAD, 32'hBEEF, 32'd100, 8'd14);
    n = 0;
    while (!(BUSY && !GO) && n < 50) begin @(negedge CLK); n++; end
    if (n >= 50) fail_now("run_wait_timeout");
    repeat (5) @(negedge CLK);
    reset_dut();
    n = 0;
    while (!wr_done && n < 400) begin @(negedge CLK); n++; end
    if (n >= 400) fail_now("wrapper_idle_timeout");
    sync();
    wr_busy = 3;
    push_job(32'h55, 32'h66, 32'd7, 8'd15);
    wait_drain();
    check("post_rst_jobs_done", JOBS_DONE, 1);

    // randomized traffic with random HOLD and wrapper timing
    sync();
    rand_wr = 1;
    rand_on = 1;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          int gap;
          gap = $urandom_range(0, 3);
          repeat (gap) sync();
          push_job($urandom, $urandom,
                   ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 1000)),
                   TAG_W'($urandom));
        end
        rand_on = 0;
      end
      begin
        while (rand_on) begin
          @(posedge CLK);
          #1 HOLD = ($urandom_range(0, 3) == 0);
        end
        HOLD = 1'b0;
      end
    join
    wait_drain();
    @(negedge CLK);
    check("final_qcount", QCOUNT, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL global_timeout: simulation exceeded time limit at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/job_scheduler.md
JOB_SCHEDULER -- requirements
Module: job_scheduler

Interface
REQ-001 Parameter DEPTH, default 4, job queue depth (power of 2, >= 2).
REQ-002 Parameter TAG_W, default 8, job tag width.
REQ-003 Port CLK  input  1  sole clock; all logic rising-edge.
REQ-004 Port RST  input  1  synchronous, active-high reset.
REQ-005 Port JOB_VALID  input  1  job descriptor offered.
REQ-006 Port JOB_READY  output  1  queue can accept a descriptor.
REQ-007 Port JOB_SRC, JOB_DST, JOB_SIZE  input  32 each  descriptor: source address, destination address, stream length in cycles.
REQ-008 Port JOB_TAG  input  TAG_W  caller tag echoed on completion.
REQ-009 Port HOLD  input  1  inhibits launching new jobs; an in-flight job is unaffected.
REQ-010 Port GO  output  1  start request to the bitstream wrapper.
REQ-011 Port DONE  input  1  wrapper idle indication: 1 = idle, 0 = job in progress or finishing.
REQ-012 Port SRC, DST, SIZE  output  32 each  descriptor fields of the current job, driven to the wrapper.
REQ-013 Port CPL_VALID  output  1  one-cycle completion pulse, no backpressure.
REQ-014 Port CPL_TAG  output  TAG_W  tag of the completed job, valid with CPL_VALID.
REQ-015 Port CPL_ERR  output  1  job rejected (SIZE == 0), valid with CPL_VALID.
REQ-016 Port QCOUNT  output  clog2(DEPTH)+1  number of queued jobs, excluding the in-flight job.
REQ-017 Port BUSY  output  1  high whenever state is not S_IDLE.
REQ-018 Port JOBS_DONE  output  16  count of completion pulses, wraps modulo 2^16.

Function
REQ-019 Queue SHALL be a FIFO of DEPTH entries {SRC, DST, SIZE, TAG}; push on JOB_VALID && JOB_READY; JOB_READY = (QCOUNT != DEPTH), regardless of any same-cycle pop.
REQ-020 Simultaneous push and pop in one cycle SHALL leave QCOUNT unchanged and preserve order; read/write pointers wrap modulo DEPTH.
REQ-021 FSM states: S_IDLE, S_LAUNCH, S_RUN, S_CPL.
REQ-022 S_IDLE: if queue non-empty && !HOLD && DONE, pop head into registered SRC/DST/SIZE/tag; go to S_CPL with error flag set if the popped SIZE == 0, else go to S_LAUNCH; otherwise stay.
REQ-023 S_LAUNCH: GO = 1; when DONE == 0 is sampled, go to S_RUN.
REQ-024 S_RUN: GO = 0; when DONE == 1 is sampled, go to S_CPL.
REQ-025 S_CPL: CPL_VALID = 1 for exactly one cycle; CPL_ERR = latched error flag; JOBS_DONE increments; go to S_IDLE and clear the error flag.
REQ-026 GO SHALL be high only in S_LAUNCH and SHALL be a function of state only.
REQ-027 SRC/DST/SIZE SHALL stay constant from the pop cycle until the next pop.
REQ-028 A SIZE == 0 job SHALL never assert GO.
REQ-029 Latency: descriptor accepted at edge t into an empty queue, with DONE = 1 and HOLD = 0, gives GO = 1 during cycle t+2.
REQ-030 Back-to-back jobs: from S_CPL, the next launch occurs no earlier than 2 cycles later (S_IDLE pop, then S_LAUNCH).
REQ-031 HOLD asserted while in S_LAUNCH or S_RUN SHALL not alter the sequence; it only blocks the S_IDLE pop.

Reset
REQ-032 On RST: queue emptied (QCOUNT = 0), state = S_IDLE, GO = 0, CPL_VALID = 0, CPL_ERR = 0, CPL_TAG = 0, SRC = DST = SIZE = 0, JOBS_DONE = 0, BUSY = 0; JOB_READY = 1 from the first cycle after reset.
REQ-033 Reset mid-job discards the in-flight job with no completion pulse; the next launch waits until DONE == 1 per REQ-022.

Verification
REQ-034 Single job {SRC=0x1000, DST=0x2000, SIZE=256, TAG=5}; wrapper model drops DONE 1 cycle after GO and raises it 300 cycles later -> GO high exactly 1 cycle; SRC/DST/SIZE = 0x1000/0x2000/256 throughout; one CPL_VALID with TAG=5, ERR=0; JOBS_DONE = 1.
REQ-035 Push 5 jobs back-to-back with DEPTH=4 and a busy wrapper -> 5th is held off by JOB_READY = 0 until the first pop; completions in order with tags 0..4; QCOUNT never exceeds 4.
REQ-036 Job with SIZE=0 and TAG=9 queued between two valid jobs -> no GO for it; CPL_VALID with TAG=9, ERR=1; neighbouring jobs complete normally.
REQ-037 HOLD=1 with 2 jobs queued -> GO stays 0 and QCOUNT = 2; HOLD=0 -> first GO 2 cycles later.
REQ-038 DONE held 0 (wrapper still finishing) with a job queued -> no pop, GO = 0; DONE rises -> pop, then GO.
REQ-039 RST asserted during S_RUN -> all outputs reach REQ-032 values the next cycle; no CPL_VALID; JOBS_DONE = 0.
